mem_stage: RTL and testbench

Memory-access pipeline stage, directly downstream of the execute stage. It registers the EX→MEM bus and selects, aligns and extends load data from the synchronous data SRAM. It produces the MEM→WB bus and the MEM forwarding bus consumed by decode. Its stall behaviour matches the rest of the pipeline: hold, bubble or advance.

---
 rtl/mem_stage_pkg.sv | 63 ++++++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage_load_align.sv | 36 +++
 rtl/mem_stage.sv | 89 ++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and bus layouts for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 150;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 38;
    localparam int STALL_BUS_WD = 6;

    // Positions of the MEM and WB stages in the stall vector.
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // One-hot memory operation, MSB first as carried on the EX bus.
    typedef struct packed {
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lw;
        logic sb;
        logic sh;
        logic sw;
    } mem_op_t;

    // The load half of mem_op; this is all the aligner needs to see.
    typedef struct packed {
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lw;
    } load_op_t;

    typedef struct packed {
        logic [65:0] hilo_bus;
        mem_op_t     mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [65:0] hilo_bus;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_rf_t;

endpackage

// File: rtl/mem_stage_if.sv
// Buses around the MEM stage: EX input, SRAM read data, stall vector,
// and the WB / forwarding outputs.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [STALL_BUS_WD-1:0] stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

    // Upstream pipeline / environment side.
    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_rf_bus
    );

    // The MEM stage itself.
    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_rf_bus
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half/word from the SRAM read word and
// sign- or zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  load_op_t    load_op,
    input  logic [1:0]  a,
    input  logic [31:0] rd,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half-word alignment uses only a[1]; a[0] is ignored for halves.
    assign byte_sel = rd[{a, 3'b000} +: 8];
    assign half_sel = a[1] ? rd[31:16] : rd[15:0];

    // Extend the selected lane according to the load type.
    always_comb begin
        // NOTE: default first so every path assigns load_data and no latch is inferred.
        load_data = '0;
        if (load_op.lb) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op.lbu) begin
            load_data = {24'h0, byte_sel};
        end else if (load_op.lh) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (load_op.lhu) begin
            load_data = {16'h0, half_sel};
        end else if (load_op.lw) begin
            load_data = rd;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, holds SRAM read data across
// stalls, aligns loads and drives the WB and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    ex_to_mem_t  ex_in;
    ex_to_mem_t  bus_r;
    logic        fresh;
    logic [31:0] rdata_h;

    logic        stall_mem;
    logic        stall_wb;
    logic [31:0] rd;
    load_op_t    load_op;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    mem_to_wb_t  wb_out;
    mem_to_rf_t  rf_out;
    logic        unused_bits;

    assign ex_in     = bus.ex_to_mem_bus;
    assign stall_mem = bus.stall[STALL_MEM];
    assign stall_wb  = bus.stall[STALL_WB];

    // Pipeline register with bubble/advance/hold; rdata_h snapshots the
    // SRAM word during an instruction's first MEM cycle so later hold
    // cycles still see the data it was issued against.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            bus_r   <= '0;
            fresh   <= 1'b0;
            rdata_h <= '0;
        end else begin
            if (fresh) begin
                rdata_h <= bus.data_sram_rdata;
            end
            if (stall_mem == STOP && stall_wb == NO_STOP) begin
                bus_r <= '0;
                fresh <= 1'b0;
            end else if (stall_mem == NO_STOP) begin
                bus_r <= ex_in;
                fresh <= 1'b1;
            end else begin
                fresh <= 1'b0;
            end
        end
    end

    assign rd      = fresh ? bus.data_sram_rdata : rdata_h;
    assign load_op = bus_r.mem_op[7:3];

    load_align u_load_align (
        .load_op   (load_op),
        .a         (bus_r.ex_result[1:0]),
        .rd        (rd),
        .load_data (load_data)
    );

    assign rf_wdata = bus_r.sel_rf_res ? load_data : bus_r.ex_result;

    assign wb_out = '{
        hilo_bus: bus_r.hilo_bus,
        pc:       bus_r.pc,
        rf_we:    bus_r.rf_we,
        rf_waddr: bus_r.rf_waddr,
        rf_wdata: rf_wdata
    };

    assign rf_out = '{
        rf_we:    bus_r.rf_we,
        rf_waddr: bus_r.rf_waddr,
        rf_wdata: rf_wdata
    };

    assign bus.mem_to_wb_bus = wb_out;
    assign bus.mem_to_rf_bus = rf_out;

    // Store controls and other stages' stall bits are not used here.
    assign unused_bits = ^{bus_r.data_ram_en, bus_r.data_ram_wen,
                           bus_r.mem_op.sb, bus_r.mem_op.sh, bus_r.mem_op.sw,
                           bus.stall[5], bus.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load table, stall/bubble/reset
// sequences, then randomized traffic against an instruction-level model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if mif ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    localparam logic [5:0] ST_RUN  = 6'b000000;
    localparam logic [5:0] ST_HOLD = 6'b011000;
    localparam logic [5:0] ST_BUB  = 6'b001000;

    localparam logic [7:0] OP_LB  = 8'h80;
    localparam logic [7:0] OP_LBU = 8'h40;
    localparam logic [7:0] OP_LH  = 8'h20;
    localparam logic [7:0] OP_LHU = 8'h10;
    localparam logic [7:0] OP_LW  = 8'h08;
    localparam logic [7:0] OP_SB  = 8'h04;
    localparam logic [7:0] OP_SH  = 8'h02;
    localparam logic [7:0] OP_SW  = 8'h01;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the instruction currently in MEM, whether this is its first
    // MEM cycle, and the SRAM word it saw on that first cycle.
    ex_to_mem_t  m_instr;
    logic        m_first;
    logic [31:0] m_word;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        int unsigned b;
        int unsigned h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (a >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
        if (op == OP_LB)  return (b >= 128) ? b - 256 : b;
        if (op == OP_LBU) return b;
        if (op == OP_LH)  return (h >= 32768) ? h - 65536 : h;
        if (op == OP_LHU) return h;
        if (op == OP_LW)  return rd;
        return 32'h0;
    endfunction

    function automatic ex_to_mem_t rand_ex();
        ex_to_mem_t  e;
        logic [95:0] t;
        logic [7:0]  ops [9];
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 8'h00};
        t = {$urandom(), $urandom(), $urandom()};
        e.hilo_bus     = t[65:0];
        e.mem_op       = ops[$urandom_range(0, 8)];
        e.pc           = $urandom();
        e.data_ram_en  = 1'($urandom_range(0, 1));
        e.data_ram_wen = 4'($urandom_range(0, 15));
        e.sel_rf_res   = 1'($urandom_range(0, 1));
        e.rf_we        = 1'($urandom_range(0, 1));
        e.rf_waddr     = 5'($urandom_range(0, 31));
        e.ex_result    = $urandom();
        return e;
    endfunction

    // Apply inputs for one edge, update the model, then present the SRAM
    // word for the new MEM cycle away from the clock edge.
    task automatic drive(input ex_to_mem_t ex, input logic [5:0] st, input logic r,
                         input logic [31:0] rdata_next);
        mif.ex_to_mem_bus = ex;
        mif.stall         = st;
        rst               = r;
        @(posedge clk);
        if (r) begin
            m_instr = '0;
            m_first = 1'b0;
            m_word  = 32'h0;
        end else if (st[STALL_MEM] && !st[STALL_WB]) begin
            m_instr = '0;
            m_first = 1'b0;
        end else if (!st[STALL_MEM]) begin
            m_instr = ex;
            m_first = 1'b1;
        end else begin
            if (m_first) m_word = mif.data_sram_rdata;
            m_first = 1'b0;
        end
        #1 mif.data_sram_rdata = rdata_next;
        #1;
    endtask

    task automatic check_model(input string name);
        logic [31:0] rd;
        logic [31:0] wdata;
        mem_to_wb_t  exp_wb;
        mem_to_rf_t  exp_rf;
        rd    = m_first ? mif.data_sram_rdata : m_word;
        wdata = m_instr.sel_rf_res ? ref_load(m_instr.mem_op, m_instr.ex_result[1:0], rd)
                                   : m_instr.ex_result;
        exp_wb = '{m_instr.hilo_bus, m_instr.pc, m_instr.rf_we, m_instr.rf_waddr, wdata};
        exp_rf = '{m_instr.rf_we, m_instr.rf_waddr, wdata};
        check({name, "_wb"}, mif.mem_to_wb_bus, exp_wb);
        check({name, "_rf"}, mif.mem_to_rf_bus, exp_rf);
    endtask

    function automatic ex_to_mem_t make_ex(input logic [7:0] op, input logic [31:0] addr,
                                           input logic sel);
        ex_to_mem_t e;
        e            = rand_ex();
        e.mem_op     = op;
        e.ex_result  = addr;
        e.sel_rf_res = sel;
        e.rf_we      = 1'b1;
        e.rf_waddr   = 5'd5;
        return e;
    endfunction

    initial begin
        vec_t        vecs [9];
        ex_to_mem_t  ex;
        mem_to_wb_t  exp_wb;
        mem_to_rf_t  exp_rf;
        logic [135:0] held;
        logic        r;
        logic [5:0]  st;

        vecs[0] = '{"lb_a1",     OP_LB,  32'h1000_0001, 32'h1234_80FF, 1'b1, 32'hFFFF_FF80};
        vecs[1] = '{"lbu_a1",    OP_LBU, 32'h1000_0001, 32'h1234_80FF, 1'b1, 32'h0000_0080};
        vecs[2] = '{"lh_a2",     OP_LH,  32'h1000_0002, 32'h9ABC_0001, 1'b1, 32'hFFFF_9ABC};
        vecs[3] = '{"lhu_a0",    OP_LHU, 32'h1000_0000, 32'h9ABC_0001, 1'b1, 32'h0000_0001};
        vecs[4] = '{"lw",        OP_LW,  32'h1000_0000, 32'h9ABC_0001, 1'b1, 32'h9ABC_0001};
        vecs[5] = '{"non_load",  OP_SW,  32'hDEAD_BEEF, 32'h5555_AAAA, 1'b0, 32'hDEAD_BEEF};
        vecs[6] = '{"lb_a3",     OP_LB,  32'h2000_0003, 32'h8012_3456, 1'b1, 32'hFFFF_FF80};
        vecs[7] = '{"lhu_a3",    OP_LHU, 32'h2000_0003, 32'h9ABC_0001, 1'b1, 32'h0000_9ABC};
        vecs[8] = '{"lb_a0_pos", OP_LB,  32'h2000_0000, 32'hFFFF_FF7F, 1'b1, 32'h0000_007F};

        mif.ex_to_mem_bus   = '0;
        mif.stall           = ST_RUN;
        mif.data_sram_rdata = 32'h0;
        m_instr = '0;
        m_first = 1'b0;
        m_word  = 32'h0;

        // Reset state.
        drive('0, ST_RUN, 1'b1, 32'hFFFF_FFFF);
        drive(rand_ex(), ST_RUN, 1'b1, 32'hFFFF_FFFF);
        check("reset_wb", mif.mem_to_wb_bus, '0);
        check("reset_rf", mif.mem_to_rf_bus, '0);

        // Directed load / pass-through table.
        foreach (vecs[i]) begin
            ex = make_ex(vecs[i].op, vecs[i].addr, vecs[i].sel);
            drive(ex, ST_RUN, 1'b0, vecs[i].rdata);
            exp_wb = '{ex.hilo_bus, ex.pc, 1'b1, 5'd5, vecs[i].exp};
            exp_rf = '{1'b1, 5'd5, vecs[i].exp};
            check({vecs[i].name, "_wb"}, mif.mem_to_wb_bus, exp_wb);
            check({vecs[i].name, "_rf"}, mif.mem_to_rf_bus, exp_rf);
        end

        // Stall hold: outputs frozen while the SRAM output moves on.
        ex = make_ex(OP_LW, 32'h3000_0000, 1'b1);
        drive(ex, ST_RUN, 1'b0, 32'h1111_1111);
        check("hold_c0", mif.mem_to_rf_bus, {1'b1, 5'd5, 32'h1111_1111});
        held = mif.mem_to_wb_bus;
        for (int k = 1; k <= 3; k++) begin
            drive(rand_ex(), ST_HOLD, 1'b0, 32'h2222_2222);
            check($sformatf("hold_c%0d_rf", k), mif.mem_to_rf_bus, {1'b1, 5'd5, 32'h1111_1111});
            check($sformatf("hold_c%0d_wb", k), mif.mem_to_wb_bus, held);
        end

        // Bubble wins over simultaneous new EX data.
        drive(make_ex(OP_LW, 32'h0, 1'b1), ST_BUB, 1'b0, 32'h4444_4444);
        check("bubble_wb", mif.mem_to_wb_bus, '0);
        check("bubble_rf", mif.mem_to_rf_bus, '0);

        // Reset during a stalled load, then a fresh load completes.
        drive(make_ex(OP_LW, 32'h0, 1'b1), ST_RUN, 1'b0, 32'h3333_3333);
        drive(rand_ex(), ST_HOLD, 1'b0, 32'h7777_7777);
        drive(rand_ex(), ST_HOLD, 1'b1, 32'h7777_7777);
        check("rst_mid_wb", mif.mem_to_wb_bus, '0);
        check("rst_mid_rf", mif.mem_to_rf_bus, '0);
        ex = make_ex(OP_LW, 32'h4000_0000, 1'b1);
        drive(ex, ST_RUN, 1'b0, 32'h0000_00AA);
        check("after_rst_lw", mif.mem_to_rf_bus, {1'b1, 5'd5, 32'h0000_00AA});

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            st = 6'($urandom_range(0, 63));
            st[STALL_MEM] = ($urandom_range(0, 9) < 3);
            st[STALL_WB]  = ($urandom_range(0, 1) == 1);
            drive(rand_ex(), st, r, $urandom());
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
